// File: rtl/flop_pkg.sv
// flop_pkg: shared definitions for the register/counter blocks.
//   MODE_* : 3-bit operation select codes used on the mode input of
//            universal_counter_reg (and future register blocks).
package flop_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_HOLD   = 3'b000;
    localparam logic [MODE_W-1:0] MODE_LOAD   = 3'b001;
    localparam logic [MODE_W-1:0] MODE_SHL    = 3'b010;
    localparam logic [MODE_W-1:0] MODE_SHR    = 3'b011;
    localparam logic [MODE_W-1:0] MODE_UP     = 3'b100;
    localparam logic [MODE_W-1:0] MODE_DOWN   = 3'b101;
    localparam logic [MODE_W-1:0] MODE_TOGGLE = 3'b110;
    localparam logic [MODE_W-1:0] MODE_CLEAR  = 3'b111;

endpackage

// File: rtl/dff_bank.sv
// dff_bank: WIDTH-bit register with synchronous active-low reset.
//   clk_i   : clock, rising edge
//   rst_ni  : synchronous reset, active low, clears the bank to 0
//   d_i     : next-state data
//   q_o     : registered state
//   q_n_o   : bitwise complement of q_o
module dff_bank #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o,
    output logic [WIDTH-1:0] q_n_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            q_q <= '0;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o   = q_q;
    // Derived from the same flops, so q_n always moves together with q.
    assign q_n_o = ~q_q;

endmodule

// File: rtl/universal_counter_reg.sv
// universal_counter_reg: universal register -- hold, load, shift left/right,
// modulo up/down count, per-bit toggle and clear, selected by mode.
//   clk      : clock, rising edge
//   reset_n  : synchronous reset, active low, priority over everything
//   en       : operation enable (low = hold)
//   mode     : operation select (flop_pkg::MODE_*)
//   d        : load data / toggle mask
//   sin_l    : serial in for shift left (enters at bit 0)
//   sin_r    : serial in for shift right (enters at MSB)
//   q, q_n   : registered state and its complement
//   tc       : combinational terminal count, high the cycle before a wrap
module universal_counter_reg
    import flop_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_COUNT = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_l,
    input  logic             sin_r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             tc
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             at_max;
    logic             at_zero;

    // ">=" rather than "==" so a value loaded above MAX_COUNT still wraps to 0.
    assign at_max  = (q_q >= MAX_COUNT);
    assign at_zero = (q_q == '0);

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode)
                MODE_HOLD:   q_d = q_q;
                MODE_LOAD:   q_d = d;
                MODE_SHL:    q_d = {q_q[WIDTH-2:0], sin_l};
                MODE_SHR:    q_d = {sin_r, q_q[WIDTH-1:1]};
                MODE_UP:     q_d = at_max  ? '0        : q_q + ONE;
                MODE_DOWN:   q_d = at_zero ? MAX_COUNT : q_q - ONE;
                MODE_TOGGLE: q_d = q_q ^ d;
                MODE_CLEAR:  q_d = '0;
                default:     q_d = q_q;
            endcase
        end
    end

    // Looks only at the current state, so during reset (q=0) it still reports
    // a pending DOWN wrap; cascaded stages use it directly as their enable.
    assign tc = en && (((mode == MODE_UP)   && at_max) ||
                       ((mode == MODE_DOWN) && at_zero));

    dff_bank #(.WIDTH(WIDTH)) u_bank (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (q_d),
        .q_o    (q_q),
        .q_n_o  (q_n)
    );

    assign q = q_q;

endmodule

// File: doc/universal_counter_reg.md
UNIVERSAL_COUNTER_REG -- requirements
Module: universal_counter_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MAX_COUNT, default 2**WIDTH-1, giving the modulo terminal value for counting (legal range 1..2**WIDTH-1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1, the operation enable; low means hold.
REQ-006 The block SHALL have port mode, input, 3, the operation select (encoding in REQ-010).
REQ-007 The block SHALL have ports d (input, WIDTH, parallel load data), sin_l (input, 1, serial in for shift left) and sin_r (input, 1, serial in for shift right).
REQ-008 The block SHALL have ports q (output, WIDTH, registered state) and q_n (output, WIDTH, bitwise complement of q at all times).
REQ-009 The block SHALL have port tc (output, 1, combinational terminal count, see REQ-015).

Function
REQ-010 Mode encoding SHALL be: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 UP, 101 DOWN, 110 TOGGLE, 111 CLEAR.
REQ-011 With reset_n high and en low, q SHALL hold regardless of mode.
REQ-012 With en high, the next q SHALL follow the selected mode:
- HOLD: q.
- LOAD: d.
- SHL: {q[WIDTH-2:0], sin_l}.
- SHR: {sin_r, q[WIDTH-1:1]}.
- UP: 0 if q >= MAX_COUNT, else q+1.
- DOWN: MAX_COUNT if q == 0, else q-1.
- TOGGLE: q XOR d, i.e. a bitwise T-flip-flop with d as the per-bit toggle mask.
- CLEAR: 0.
REQ-013 Every operation SHALL take effect in exactly one clock; q SHALL be valid the cycle after the edge, and q_n SHALL change in the same cycle as q.
REQ-014 LOAD, SHL, SHR and TOGGLE SHALL be unrestricted by MAX_COUNT; a q above MAX_COUNT SHALL wrap to 0 on the next UP and decrement normally on DOWN.
REQ-015 tc SHALL be 1 when en=1 and either (mode=UP and q >= MAX_COUNT) or (mode=DOWN and q == 0), and SHALL be 0 otherwise.
REQ-016 tc SHALL be asserted in the cycle before a wrap occurs, so that cascaded counters use tc as the next stage's en.
REQ-017 All arithmetic SHALL be WIDTH bits unsigned, with no carry out other than tc.

Reset
REQ-018 reset_n low at a rising clk edge SHALL force q=0 and q_n=all ones, with priority over en and mode.
REQ-019 Reset asserted mid-count or mid-shift SHALL discard the operation in progress; no partial state SHALL survive.
REQ-020 reset_n SHALL have no effect between clock edges.
REQ-021 While reset_n is low, tc SHALL still follow REQ-015, evaluated on q=0.

Structure
REQ-022 The mode encoding constants SHALL live in the shared package flop_pkg, for reuse by future register blocks.
REQ-023 The storage SHALL be one sub-module, dff_bank: a WIDTH-bit register with synchronous active-low reset, data in and q/q_n out.
REQ-024 The next-state mux SHALL stay in universal_counter_reg.

Verification
REQ-025 Decade count (WIDTH=4, MAX_COUNT=9), reset then en=1, mode=UP for 12 clocks -> q = 1..9, 0, 1, 2, with tc=1 only in the cycle where q=9.
REQ-026 DOWN wrap (WIDTH=4, MAX_COUNT=9), q=0, mode=DOWN, 2 clocks -> tc=1 at q=0, then q=9, then q=8.
REQ-027 Shifts (WIDTH=8), LOAD d=0xA5, then SHL with sin_l=1 -> q=0x4B; then SHR with sin_r=0 -> q=0x25; q_n=~q in every cycle.
REQ-028 Toggle and hold, q=0x0F, TOGGLE with d=0xFF -> q=0xF0; then en=0 with mode=CLEAR for 3 clocks -> q stays 0xF0.
REQ-029 Synchronous reset, mid-count q=0x37, reset_n pulsed low between edges -> q unchanged; reset_n low across an edge with en=1, mode=LOAD -> q=0x00, q_n=0xFF.
REQ-030 Out-of-range value (WIDTH=4, MAX_COUNT=9), LOAD d=12, then UP -> tc=1 before the edge, then q=0.
